// File: rtl/fetch_unit_if.sv
// Instruction-memory read channel between the fetch unit (master) and imem (slave).
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rdy;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_rdy, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_rdy, output imem_rdata);
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, fetches over a req/rdy handshake, selects PC+4 or branch target.
// Optional FETCH_PERF_CNT_EN adds retire/taken performance counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int unsigned IMEM_WAIT_MAX = 15
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              en,
  fetch_unit_if.master      imem,
  input  logic              PCSrc,
  input  logic [31:0]       ImmExt,
  output logic [31:0]       Instr,
  output logic [6:0]        OPCODE,
  output logic [2:0]        funct3,
  output logic              funct7,
  output logic              instr_valid,
  output logic [31:0]       PC,
  output logic [31:0]       PCPlus4,
  output logic              fetch_err
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       retire_cnt,
  output logic [31:0]       taken_cnt
`endif
);

  localparam int unsigned WAIT_W   = 8;
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(IMEM_WAIT_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_nxt;
  logic [31:0]       next_pc;

  assign PCPlus4  = PC + 32'd4;
  assign next_pc  = PCSrc ? (PC + ImmExt) : PCPlus4;
  assign wait_nxt = wait_cnt + WAIT_W'(1);

  // Handshake and valid decode straight from the state register so reset drops them at once.
  assign imem.imem_req  = (state == FETCH);
  assign imem.imem_addr = PC;
  assign instr_valid    = (state == EXEC);

  assign OPCODE = Instr[6:0];
  assign funct3 = Instr[14:12];
  assign funct7 = Instr[30];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      PC        <= RESET_PC;
      Instr     <= NOP_INSN;
      fetch_err <= 1'b0;
      wait_cnt  <= '0;
`ifdef FETCH_PERF_CNT_EN
      retire_cnt <= '0;
      taken_cnt  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (en) state <= FETCH;
        end
        FETCH: begin
          if (imem.imem_rdy) begin
            Instr    <= imem.imem_rdata;
            wait_cnt <= '0;
            state    <= EXEC;
          end else begin
            wait_cnt <= wait_nxt;
            if (wait_nxt == WAIT_LAST) begin
              state     <= HALT;
              fetch_err <= 1'b1;
            end
          end
        end
        EXEC: begin
          PC <= next_pc;
`ifdef FETCH_PERF_CNT_EN
          retire_cnt <= retire_cnt + 32'd1;
          if (PCSrc) taken_cnt <= taken_cnt + 32'd1;
`endif
          // A misaligned target still lands in PC so the faulting address is visible.
          if (next_pc[1:0] != 2'b00) begin
            state     <= HALT;
            fetch_err <= 1'b1;
          end else begin
            state <= en ? FETCH : IDLE;
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus queues expected fetches/executes, a monitor checks them.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        en = 1'b0;
  logic        PCSrc = 1'b0;
  logic [31:0] ImmExt = 32'h0;
  logic [31:0] Instr;
  logic [6:0]  OPCODE;
  logic [2:0]  funct3;
  logic        funct7;
  logic        instr_valid;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        fetch_err;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] retire_cnt;
  logic [31:0] taken_cnt;
`endif

  fetch_unit_if imem();

  fetch_unit dut (
    .CLK         (CLK),
    .RST         (RST),
    .en          (en),
    .imem        (imem),
    .PCSrc       (PCSrc),
    .ImmExt      (ImmExt),
    .Instr       (Instr),
    .OPCODE      (OPCODE),
    .funct3      (funct3),
    .funct7      (funct7),
    .instr_valid (instr_valid),
    .PC          (PC),
    .PCPlus4     (PCPlus4),
    .fetch_err   (fetch_err)
`ifdef FETCH_PERF_CNT_EN
    ,
    .retire_cnt  (retire_cnt),
    .taken_cnt   (taken_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_addr[$];
  logic [63:0] exp_exec[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Monitor: every accepted fetch and every EXEC cycle must match a queued expectation.
  always @(negedge CLK) begin
    if (RST) begin
      if (imem.imem_req && imem.imem_rdy) begin
        if (exp_addr.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_fetch: got addr %h expected none", imem.imem_addr);
        end else begin
          check("imem_addr", imem.imem_addr, exp_addr.pop_front());
        end
      end
      if (instr_valid) begin
        if (exp_exec.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_exec: got instr %h pc %h expected none", Instr, PC);
        end else begin
          logic [63:0] e;
          logic [31:0] w;
          e = exp_exec.pop_front();
          w = e[63:32];
          check("Instr", Instr, w);
          check("PC_exec", PC, e[31:0]);
          check("OPCODE", 32'(OPCODE), 32'(w[6:0]));
          check("funct3", 32'(funct3), 32'(w[14:12]));
          check("funct7", 32'(funct7), 32'(w[30]));
        end
      end
    end
  end

  task automatic wait_req();
    for (int i = 0; i < 40 && !imem.imem_req; i++) step();
    if (!imem.imem_req) begin
      checks++; errors++;
      $display("FAIL wait_req_timeout: got imem_req 0 expected 1 within 40 cycles");
    end
  endtask

  // One instruction: optional wait cycles, then rdy with data, then the EXEC cycle.
  task automatic run_instr(input logic [31:0] addr, input logic [31:0] word, input int waits,
                           input logic pcsrc, input logic [31:0] imm);
    wait_req();
    exp_addr.push_back(addr);
    exp_exec.push_back({word, addr});
    imem.imem_rdy = 1'b0;
    repeat (waits) step();
    imem.imem_rdy   = 1'b1;
    imem.imem_rdata = word;
    PCSrc  = pcsrc;
    ImmExt = imm;
    step();
    imem.imem_rdy = 1'b0;
    step();
    PCSrc  = 1'b0;
    ImmExt = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    imem.imem_rdy   = 1'b1;
    imem.imem_rdata = 32'h0;
    en = 1'b1;
    step(); step();
    check("rst_PC", PC, 32'h0);
    check("rst_Instr", Instr, 32'h0000_0013);
    check("rst_instr_valid", 32'(instr_valid), 32'h0);
    check("rst_imem_req", 32'(imem.imem_req), 32'h0);
    check("rst_fetch_err", 32'(fetch_err), 32'h0);
    check("rst_PCPlus4", PCPlus4, 32'h4);
    RST = 1'b1;

    // Sequential fetch 0,4,8,C
    run_instr(32'h0, 32'h00a0_0093, 0, 1'b0, 32'h0);
    run_instr(32'h4, 32'h0020_81b3, 0, 1'b0, 32'h0);
    run_instr(32'h8, 32'h4020_8233, 0, 1'b0, 32'h0);
    run_instr(32'hC, 32'h0000_0013, 0, 1'b0, 32'h0);
    // Backward branch 0x10 + (-8) -> 0x08
    run_instr(32'h10, 32'h0000_0063, 0, 1'b1, 32'hFFFF_FFF8);
    // Three wait cycles before data
    run_instr(32'h8, 32'h0000_0063, 3, 1'b0, 32'h0);

    // en dropped during FETCH: fetch completes, then IDLE
    wait_req();
    en = 1'b0;
    run_instr(32'hC, 32'h0000_1063, 0, 1'b0, 32'h0);
    repeat (3) begin
      check("idle_imem_req", 32'(imem.imem_req), 32'h0);
      step();
    end
    check("idle_PC", PC, 32'h10);
    en = 1'b1;

    // Branch to the top of the address space, then wrap to 0 with no error
    run_instr(32'h10, 32'h0000_0013, 0, 1'b1, 32'hFFFF_FFEC);
    wait_req();
    check("top_PC", PC, 32'hFFFF_FFFC);
    check("top_PCPlus4", PCPlus4, 32'h0);
    run_instr(32'hFFFF_FFFC, 32'h0000_0013, 0, 1'b0, 32'h0);
    check("wrap_fetch_err", 32'(fetch_err), 32'h0);

    // Reset asserted mid-FETCH at 0x20
    run_instr(32'h0, 32'h0000_0013, 0, 1'b1, 32'h20);
    wait_req();
    check("midfetch_PC", PC, 32'h20);
    step();
    RST = 1'b0;
    #1;
    check("async_imem_req", 32'(imem.imem_req), 32'h0);
    check("async_PC", PC, 32'h0);
    check("async_instr_valid", 32'(instr_valid), 32'h0);
    step();
    RST = 1'b1;

    // Misaligned branch target -> HALT with PC updated
    run_instr(32'h0, 32'h0000_0013, 0, 1'b1, 32'h2);
    check("misalign_fetch_err", 32'(fetch_err), 32'h1);
    check("misalign_PC", PC, 32'h2);
    repeat (3) begin
      step();
      check("halt_imem_req", 32'(imem.imem_req), 32'h0);
      check("halt_instr_valid", 32'(instr_valid), 32'h0);
    end

    // imem never ready -> error after IMEM_WAIT_MAX cycles
    RST = 1'b0;
    step();
    RST = 1'b1;
    imem.imem_rdy = 1'b0;
    wait_req();
    repeat (14) step();
    check("wait14_imem_req", 32'(imem.imem_req), 32'h1);
    check("wait14_fetch_err", 32'(fetch_err), 32'h0);
    step();
    check("timeout_fetch_err", 32'(fetch_err), 32'h1);
    check("timeout_imem_req", 32'(imem.imem_req), 32'h0);
    imem.imem_rdy = 1'b1;
    repeat (3) step();
    check("timeout_hold_req", 32'(imem.imem_req), 32'h0);
    check("timeout_hold_PC", PC, 32'h0);
    imem.imem_rdy = 1'b0;

`ifdef FETCH_PERF_CNT_EN
    RST = 1'b0;
    step();
    check("perf_rst_retire", retire_cnt, 32'h0);
    check("perf_rst_taken", taken_cnt, 32'h0);
    RST = 1'b1;
    run_instr(32'h0,  32'h0000_0063, 0, 1'b1, 32'h8);
    run_instr(32'h8,  32'h0000_0013, 0, 1'b0, 32'h0);
    run_instr(32'hC,  32'h0000_0063, 0, 1'b1, 32'h10);
    run_instr(32'h1C, 32'h0000_0013, 0, 1'b0, 32'h0);
    run_instr(32'h20, 32'h0000_0013, 0, 1'b0, 32'h0);
    check("perf_retire", retire_cnt, 32'd5);
    check("perf_taken", taken_cnt, 32'd2);
`endif

    check("sb_addr_left", 32'(exp_addr.size()), 32'h0);
    check("sb_exec_left", 32'(exp_exec.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
